// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel 3x3 window generator: default geometry,
// window FSM states and the counter-width helper.
package sobel_pkg;

    localparam int SOBEL_PIX_W = 8;
    localparam int SOBEL_IMG_W = 640;
    localparam int SOBEL_IMG_H = 480;

    typedef enum logic [1:0] {
        WAIT_SOF,
        FILL,
        ACTIVE
    } win_state_t;

    // Width of a counter that must hold 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SOBEL_COL_W = cnt_w(SOBEL_IMG_W);
    localparam int SOBEL_ROW_W = cnt_w(SOBEL_IMG_H);

endpackage

// File: rtl/sobel_line_buffer.sv
// Single-port line buffer, one image line deep. rd_data is the word stored
// at addr before this cycle's write, so a read-modify-write of the same
// address within one cycle sees the old contents.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int WIDTH = SOBEL_PIX_W,
    parameter int DEPTH = SOBEL_IMG_W,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Old word at addr, visible in the same cycle as the write.
    always_comb rd_data = mem[addr];

    // Synchronous write.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wr_data;
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream to 3x3 interior windows (centre pixel omitted).
// Two-stage pipeline: line-buffer read / input capture, then window shift
// and output load. Optional macro SOBEL_WIN_FRAME_ERR_EN enables the sticky
// frame_err protocol flag; otherwise frame_err is tied to 0.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int PIX_W = SOBEL_PIX_W,
    parameter int IMG_W = SOBEL_IMG_W,
    parameter int IMG_H = SOBEL_IMG_H
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_data,
    output logic [PIX_W-1:0] pix_0,
    output logic [PIX_W-1:0] pix_1,
    output logic [PIX_W-1:0] pix_2,
    output logic [PIX_W-1:0] pix_3,
    output logic [PIX_W-1:0] pix_5,
    output logic [PIX_W-1:0] pix_6,
    output logic [PIX_W-1:0] pix_7,
    output logic [PIX_W-1:0] pix_8,
    output logic             win_valid,
    output logic             win_last,
    output logic             frame_err
);

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    win_state_t       state, state_nxt;
    logic [CW-1:0]    col, cur_col;
    logic [RW-1:0]    row, cur_row;
    logic             sof_pix, resync, accept, end_row, end_frame, emit;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;

    logic             s1_shift, s1_emit, s1_last;
    logic [PIX_W-1:0] s1_top, s1_mid, s1_bot;
    logic [PIX_W-1:0] t1, t2, m1, m2, b1, b2;

    // Position of the pixel on in_data; an sof pixel is always (0, 0).
    always_comb begin
        sof_pix   = in_valid & in_sof;
        resync    = sof_pix & (state != WAIT_SOF);
        accept    = in_valid & ((state != WAIT_SOF) | in_sof);
        cur_col   = sof_pix ? '0 : col;
        cur_row   = sof_pix ? '0 : row;
        end_row   = (cur_col == COL_LAST);
        end_frame = end_row & (cur_row == ROW_LAST);
        emit      = accept & ~sof_pix & (state == ACTIVE) & (cur_col >= COL_TWO);
    end

    // FSM next-state: sof from any state restarts the frame in FILL.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_SOF: if (sof_pix) state_nxt = FILL;
            FILL: begin
                if (sof_pix) state_nxt = FILL;
                else if (accept && end_row && cur_row == ROW_ONE) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (sof_pix) state_nxt = FILL;
                else if (accept && end_frame) state_nxt = WAIT_SOF;
            end
            default: state_nxt = WAIT_SOF;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_SOF;
        else     state <= state_nxt;
    end

    // Column/row counters advance on accepted pixels only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (end_row) begin
                col <= '0;
                row <= end_frame ? '0 : cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end
    end

    // lb0 holds row r-1; its displaced word cascades into lb1 (row r-2).
    sobel_line_buffer #(.WIDTH(PIX_W), .DEPTH(IMG_W), .AW(CW)) u_lb0 (
        .clk     (clk),
        .we      (accept),
        .addr    (cur_col),
        .wr_data (in_data),
        .rd_data (lb0_rd)
    );

    sobel_line_buffer #(.WIDTH(PIX_W), .DEPTH(IMG_W), .AW(CW)) u_lb1 (
        .clk     (clk),
        .we      (accept),
        .addr    (cur_col),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    // Stage 1: capture the new column of the window and its flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_shift <= 1'b0;
            s1_emit  <= 1'b0;
            s1_last  <= 1'b0;
            s1_top   <= '0;
            s1_mid   <= '0;
            s1_bot   <= '0;
        end else begin
            s1_shift <= accept;
            s1_emit  <= emit;
            s1_last  <= emit & end_frame;
            if (accept) begin
                s1_top <= lb1_rd;
                s1_mid <= lb0_rd;
                s1_bot <= in_data;
            end
        end
    end

    // Window shift registers: one step per accepted pixel, independent of stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {t1, t2, m1, m2, b1, b2} <= '0;
        end else if (s1_shift) begin
            t1 <= s1_top;  t2 <= t1;
            m1 <= s1_mid;  m2 <= m1;
            b1 <= s1_bot;  b2 <= b1;
        end
    end

    // Stage 2: load outputs for an emitting pixel; a resync pixel in the
    // same cycle kills the window still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            {pix_0, pix_1, pix_2, pix_3, pix_5, pix_6, pix_7, pix_8} <= '0;
        end else begin
            win_valid <= s1_emit & ~resync;
            win_last  <= s1_emit & s1_last & ~resync;
            if (s1_emit && !resync) begin
                pix_0 <= t2;  pix_1 <= t1;  pix_2 <= s1_top;
                pix_3 <= m2;                pix_5 <= s1_mid;
                pix_6 <= b2;  pix_7 <= b1;  pix_8 <= s1_bot;
            end
        end
    end

`ifdef SOBEL_WIN_FRAME_ERR_EN
    logic frame_done;

    // Sticky error: sof mid-frame, or stray pixels once a frame has completed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (accept && end_frame && state == ACTIVE && !sof_pix) frame_done <= 1'b1;
            if (resync || (in_valid && !in_sof && state == WAIT_SOF && frame_done))
                frame_err <= 1'b1;
        end
    end
`else
    // Error reporting disabled.
    always_comb frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen at IMG_W=IMG_H=4, pixel = row*16+col.
module tb_sobel_window_gen;

    localparam int PW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_sof;
    logic [PW-1:0] in_data;
    logic [PW-1:0] pix_0, pix_1, pix_2, pix_3, pix_5, pix_6, pix_7, pix_8;
    logic          win_valid, win_last, frame_err;

    sobel_window_gen #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .pix_0(pix_0), .pix_1(pix_1), .pix_2(pix_2), .pix_3(pix_3), .pix_5(pix_5),
        .pix_6(pix_6), .pix_7(pix_7), .pix_8(pix_8),
        .win_valid(win_valid), .win_last(win_last), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [63:0] pix;
        logic        last;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   n_win = 0;
    bit   in_frame = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pv(input int r, input int c);
        return 8'(r * 16 + c);
    endfunction

    task automatic drive_pixel(input int r, input int c);
        exp_t e;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_sof   = (r == 0 && c == 0);
        in_data  = pv(r, c);
        if (r == 0 && c == 0) begin
            if (in_frame)
                while (sb.size() > 0 && sb[sb.size()-1].due > cyc) sb.delete(sb.size()-1);
            in_frame = 1'b1;
        end
        if (r >= 2 && c >= 2) begin
            e.pix  = {pv(r-2, c-2), pv(r-2, c-1), pv(r-2, c), pv(r-1, c-2),
                      pv(r-1, c), pv(r, c-2), pv(r, c-1), pv(r, c)};
            e.last = (r == H-1 && c == W-1);
            e.due  = cyc + 2;
            sb.push_back(e);
        end
        if (r == H-1 && c == W-1) in_frame = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_sof   = 1'b0;
        end
    endtask

    task automatic send_frame(input int npix, input int gap);
        for (int i = 0; i < npix; i++) begin
            drive_pixel(i / W, i % W);
            idle(gap);
        end
    endtask

    exp_t got_e;
    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                check("missing_win", 64'(cyc), 64'(sb[0].due));
                void'(sb.pop_front());
            end
            if (win_valid) begin
                n_win++;
                if (sb.size() == 0) begin
                    check("unexpected_win", 64'(win_valid), 64'(0));
                end else begin
                    got_e = sb.pop_front();
                    check("pix", {pix_0, pix_1, pix_2, pix_3, pix_5, pix_6, pix_7, pix_8}, got_e.pix);
                    check("last", 64'(win_last), 64'(got_e.last));
                    check("latency", 64'(cyc), 64'(got_e.due));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int  base;
    logic exp_err;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(win_valid), 64'(0));
        check("rst_last", 64'(win_last), 64'(0));
        check("rst_pix", {pix_0, pix_1, pix_2, pix_3, pix_5, pix_6, pix_7, pix_8}, 64'(0));
        check("rst_err", 64'(frame_err), 64'(0));
        rst = 1'b0;

        // Pixels with no sof are ignored.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_sof = 1'b0; in_data = 8'(8'hA0 + i);
        end
        idle(4);
        check("nosof_cnt", 64'(n_win), 64'(0));
        check("nosof_err", 64'(frame_err), 64'(0));

        // Continuous frame.
        base = n_win;
        send_frame(W * H, 0);
        idle(4);
        check("cont_cnt", 64'(n_win - base), 64'(4));
        check("hold_p8", 64'(pix_8), 64'(8'h33));
        check("hold_p0", 64'(pix_0), 64'(8'h11));
        check("cont_err", 64'(frame_err), 64'(0));

        // in_valid toggling every cycle.
        base = n_win;
        send_frame(W * H, 1);
        idle(4);
        check("gap_cnt", 64'(n_win - base), 64'(4));

        // Resync at (2,3): pending (2,2) window is dropped, new frame restarts.
        base = n_win;
        send_frame(11, 0);
        send_frame(W * H, 0);
        idle(4);
        check("resync_cnt", 64'(n_win - base), 64'(4));
`ifdef SOBEL_WIN_FRAME_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        check("resync_err", 64'(frame_err), 64'(exp_err));

        // Reset during row 3 with the (3,2) window in flight.
        base = n_win;
        send_frame(15, 0);
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
        sb.delete();
        in_frame = 1'b0;
        #1;
        check("midrst_cnt", 64'(n_win - base), 64'(2));
        check("midrst_valid", 64'(win_valid), 64'(0));
        check("midrst_pix", {pix_0, pix_1, pix_2, pix_3, pix_5, pix_6, pix_7, pix_8}, 64'(0));
        check("midrst_err", 64'(frame_err), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        base = n_win;
        send_frame(W * H, 0);
        idle(4);
        check("postrst_cnt", 64'(n_win - base), 64'(4));
        check("postrst_err", 64'(frame_err), 64'(0));

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Upstream stage of the Sobel masking stage: turns a raster pixel stream into 3x3 neighbourhoods.
- Outputs the eight non-centre pixels of each window as pix_0..pix_8 (no pix_4), with a window-valid strobe.
- Uses two internal line buffers.
- Only interior windows are emitted; border rows and columns produce no window.

Parameters:
- PIX_W, 8, pixel bit width
- IMG_W, 640, pixels per line (>= 3)
- IMG_H, 480, lines per frame (>= 3)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  in_data carries a pixel this cycle
- in_sof  in  1  qualifies the first pixel of a frame; sampled only when in_valid=1
- in_data  in  PIX_W  raster-order pixel
- pix_0, pix_1, pix_2  out  PIX_W each  top row of window, left/centre/right
- pix_3, pix_5  out  PIX_W each  middle row of window, left/right
- pix_6, pix_7, pix_8  out  PIX_W each  bottom row of window, left/centre/right
- win_valid  out  1  window outputs valid this cycle
- win_last  out  1  with win_valid: last window of the frame
- frame_err  out  1  sticky protocol error; see Optional Feature

Behaviour:
- Reset (asynchronous, active-high):
  - FSM enters WAIT_SOF.
  - Column and row counters clear to 0.
  - All pix_* outputs, win_valid, win_last and frame_err clear to 0.
  - Line-buffer contents are don't-care.
- FSM states:
  - WAIT_SOF: in_valid without in_sof is ignored. in_valid with in_sof accepts that pixel as (row 0, col 0) and moves to FILL.
  - FILL: rows 0-1 are written into the line buffers; no windows are emitted. Accepting the last pixel of row 1 moves to ACTIVE.
  - ACTIVE: rows 2..IMG_H-1. Accepting pixel (IMG_H-1, IMG_W-1) returns to WAIT_SOF.
- Counters:
  - col increments on each accepted pixel and wraps from IMG_W-1 to 0.
  - row increments when col wraps.
  - Cycles with in_valid=0 are stalls: no state change and no output strobe.
- Line buffers:
  - lb0 holds row r-1; lb1 holds row r-2.
  - Read-before-write at address col: the old lb0 word moves to lb1, and in_data is written to lb0.
- Window shift registers:
  - Three columns deep per row; they shift only on accepted pixels.
- Window geometry: for an accepted pixel at (r, c) with r>=2 and c>=2, the window is centred at (r-1, c-1).
  - pix_0 = (r-2, c-2)
  - pix_1 = (r-2, c-1)
  - pix_2 = (r-2, c)
  - pix_3 = (r-1, c-2)
  - pix_5 = (r-1, c)
  - pix_6 = (r, c-2)
  - pix_7 = (r, c-1)
  - pix_8 = (r, c)
- Latency and output timing:
  - win_valid pulses exactly 2 clk cycles after the in_valid cycle of pixel (r, c).
  - The window is emitted for every accepted pixel with r>=2 and c>=2, i.e. (IMG_W-2)*(IMG_H-2) windows per frame.
  - pix_* outputs hold their last value while win_valid=0.
- win_last: asserted with the window for pixel (IMG_H-1, IMG_W-1).
- in_sof in FILL or ACTIVE (mid-frame resync):
  - The pixel is taken as (0, 0) of a new frame and the FSM goes to FILL.
  - Windows still in the 2-cycle pipeline are flushed: win_valid is suppressed.
- Row edges: windows never straddle lines, because emission needs c>=2 on the current row.
- Reset mid-operation: immediate return to the reset state; in-flight windows are lost.

Optional Feature:
- Macro: SOBEL_WIN_FRAME_ERR_EN.
- Defined:
  - frame_err sets on in_sof during FILL or ACTIVE.
  - It also sets on in_valid without in_sof in WAIT_SOF after at least one frame has completed.
  - It stays set until rst.
- Undefined: frame_err is tied to 0 and the error logic is absent. Resync behaviour is unchanged.

Decomposition:
- Shared package sobel_pkg:
  - PIX_W, IMG_W, IMG_H default constants.
  - Window FSM state enum (WAIT_SOF, FILL, ACTIVE).
  - Counter width constants derived via $clog2(IMG_W) and $clog2(IMG_H).
- One sub-module, sobel_line_buffer:
  - Single-port synchronous RAM, depth IMG_W, width PIX_W.
  - Read-before-write; instantiated twice.

Test Plan (IMG_W=4, IMG_H=4, pixel value = row*16 + col, sof on first pixel):
- Continuous stream → first win_valid 2 cycles after pixel 0x22. Values: pix_0..2 = 00,01,02; pix_3 = 10; pix_5 = 12; pix_6..8 = 20,21,22.
- Same frame → exactly 4 win_valid pulses. Only the fourth has win_last=1, with pix_8=0x33 and pix_0=0x11.
- in_valid toggled 1/0 every cycle → same 4 windows with identical values, each 2 cycles after its completing pixel.
- Pixels before any sof → no outputs; a later sof frame behaves as in scenario 1.
- sof reasserted at pixel (2, 3) of frame 1 → the pending window is suppressed. The frame restarts and the next window equals the scenario-1 window of the new frame. frame_err=1 only when SOBEL_WIN_FRAME_ERR_EN is defined.
- rst pulsed during row 3 → all outputs go to 0 immediately. The FSM waits for sof and the next full frame produces 4 correct windows.
